// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store engine with a single-beat data bus
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Last counter value allowed in REQ before the access is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt_q;
  logic [31:0] load_data_q;

  logic        req_w;
  logic        is_byte_w;
  logic        is_half_w;
  logic        misal_w;
  logic        accept_w;
  logic        timeout_w;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted_w;
  logic [31:0] load_fmt_d;

  // Decode access size from funct3; unused codes fall through to word.
  always_comb begin
    req_w     = mem_read | mem_write;
    is_byte_w = (funct3[1:0] == 2'b00);
    is_half_w = (funct3[1:0] == 2'b01);
    misal_w   = (is_half_w & addr[0]) |
                (~is_byte_w & ~is_half_w & (addr[1:0] != 2'b00));
    accept_w  = (state_q == ST_IDLE) & req_w & ~misal_w;
    timeout_w = (state_q == ST_REQ) & ~bus_ack & (cnt_q == TMO_LAST);
  end

  // Byte enables and lane-replicated store data for the incoming access.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data;
    if (is_byte_w) begin
      be_d    = 4'b0001 << addr[1:0];
      wdata_d = {4{store_data[7:0]}};
    end else if (is_half_w) begin
      be_d    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{store_data[15:0]}};
    end
  end

  // Align returned data to bit 0 and extend according to the latched size.
  always_comb begin
    shifted_w = bus_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_fmt_d = {{24{shifted_w[7]}}, shifted_w[7:0]};
      3'b100:  load_fmt_d = {24'd0, shifted_w[7:0]};
      3'b001:  load_fmt_d = {{16{shifted_w[15]}}, shifted_w[15:0]};
      3'b101:  load_fmt_d = {16'd0, shifted_w[15:0]};
      default: load_fmt_d = shifted_w;
    endcase
  end

  // Access FSM: launch in IDLE, wait for ack or timeout in REQ, release pipeline in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_be_q    <= 4'd0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      cnt_q       <= 8'd0;
      load_data_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_w) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_write;
            bus_addr_q  <= {addr[31:2], 2'b00};
            bus_be_q    <= be_d;
            bus_wdata_q <= wdata_d;
            funct3_q    <= funct3;
            off_q       <= addr[1:0];
            cnt_q       <= 8'd0;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack arriving on the final cycle still completes the access.
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            if (!bus_we_q) load_data_q <= load_fmt_d;
            state_q   <= ST_DONE;
          end else if (cnt_q == TMO_LAST) begin
            bus_req_q <= 1'b0;
            if (!bus_we_q) load_data_q <= 32'd0;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DONE: begin
          // Request lines still carry the finished instruction here.
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall      = rst_n & (accept_w | (state_q == ST_REQ));
  assign misaligned = rst_n & (state_q == ST_IDLE) & req_w & misal_w;
  assign bus_fault  = rst_n & timeout_w;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_be     = bus_be_q;
  assign load_data  = load_data_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store engine that turns the decoded `mem_read` / `mem_write` controls, the `funct3` size field and the ALU-computed address into single-beat transactions on the data-memory bus. It stalls the pipeline until the bus responds and performs byte-enable generation and store-data replication. It also aligns and sign/zero-extends load data, and flags misaligned accesses and bus timeouts. It sits between the EX/MEM pipeline register and the data-memory port.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles in REQ without `bus_ack` before abort; legal range 2..255.

Ports:
- `clk` in 1: single clock; every register updates on the rising edge.
- `rst_n` in 1: reset; **synchronous, active-low**.
- `mem_read` in 1: load request from the control path (MEM stage).
- `mem_write` in 1: store request; takes priority over `mem_read` if both are set.
- `funct3` in 3: access size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU; any other code is treated as W.
- `addr` in 32: byte address.
- `store_data` in 32: rs2 value.
- `load_data` out 32: aligned, extended load result.
- `stall` out 1: hold the pipeline.
- `misaligned` out 1: one-cycle fault pulse.
- `bus_fault` out 1: one-cycle timeout pulse.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32, `bus_wdata` out 32, `bus_be` out 4: registered request outputs.
- `bus_ack` in 1, `bus_rdata` in 32: bus response.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, request seen (`mem_read|mem_write`) and aligned:
  - Latch `bus_we = mem_write`, `bus_addr = {addr[31:2],2'b00}`, `bus_be`, `bus_wdata`, `funct3` and `addr[1:0]`.
  - Assert `bus_req`, clear the timeout counter, go to REQ.
- IDLE, request seen but misaligned:
  - Misaligned means H/HU/SH with `addr[0]=1`, or W with `addr[1:0]≠0`.
  - No bus access; `misaligned`=1 this cycle (combinational); `stall`=0; stay in IDLE; `load_data` unchanged.
- REQ:
  - `bus_req` held; `bus_addr`, `bus_we`, `bus_be` and `bus_wdata` are stable.
  - On `bus_ack`: drop `bus_req`. For a load, register the formatted `bus_rdata` into `load_data`. Go to DONE.
  - Otherwise the counter increments. When the counter equals `TIMEOUT-1` without ack: drop `bus_req`, pulse `bus_fault`, load `load_data`=0 for a load, go to DONE.
  - Ack in the same cycle as the timeout: the ack wins and there is no fault.
- DONE:
  - `stall`=0 and the pipeline advances at this edge.
  - Requests are ignored, because they still belong to the finished instruction.
  - Next state is always IDLE.
- `stall` = (IDLE ∧ request ∧ aligned) ∨ REQ.
- Byte enables:
  - B: `1<<addr[1:0]`.
  - H: `0011` if `addr[1]`=0, else `1100`.
  - W: `1111`.
  - Loads drive the same enables.
- Store data:
  - SB: byte replicated ×4.
  - SH: halfword replicated ×2.
  - SW: as is.
- Load formatting:
  - Shift `bus_rdata` right by `8*addr[1:0]`.
  - Take 8, 16 or 32 bits.
  - Sign-extend when `funct3[2]`=0, zero-extend otherwise.
- `bus_ack` outside REQ is ignored.
- Reset values: state IDLE; `load_data`, `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_be` and the counter all 0; `stall`, `misaligned` and `bus_fault` are 0 while `rst_n`=0.
- Reset in REQ: `bus_req` is low after that edge; the pending ack is dropped.

## Timing
- Best case: request at cycle 0 (`stall`=1), `bus_req` high in cycle 1, ack in cycle 1, DONE in cycle 2 (`stall`=0, `load_data` valid).
- Total: 3 cycles per access; `stall` is high for 2 + N cycles for an ack delayed N cycles.
- Back-to-back accesses: the second request is accepted in the IDLE cycle after DONE.
- Timeout: `bus_req` high for exactly `TIMEOUT` cycles; `bus_fault` pulses in the last one; DONE follows the next cycle.
- `load_data` holds its value until the next completed load.

## Test plan
- LW at addr 0x100 with `bus_rdata`=0xDEADBEEF, ack in the first REQ cycle -> `bus_addr`=0x100, `bus_be`=1111, `stall` high for 2 cycles, `load_data`=0xDEADBEEF in DONE.
- LB at 0x103 with rdata 0x80FF_FF00 -> `bus_be`=1000, `load_data`=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x206 with `store_data`=0x1234ABCD -> `bus_addr`=0x204, `bus_be`=1100, `bus_wdata`=0xABCDABCD, `bus_we`=1.
- LW at 0x102 -> `misaligned`=1 for one cycle, `bus_req` never rises, `stall`=0, `load_data` unchanged.
- Ack withheld with `TIMEOUT`=16 -> `bus_req` high for 16 cycles, `bus_fault` pulses on the 16th, `load_data`=0, then DONE and IDLE. Ack delayed 3 cycles -> `stall` high for 5 cycles with no fault.
- `rst_n` driven low in the second REQ cycle -> `bus_req`=0 and state IDLE after the edge. A late ack afterwards -> no change to `load_data`.
